multicycle_control_unit: RTL and testbench

- Moore-style multicycle controller that sequences the headless accumulator datapath through fetch, decode, execute, memory and writeback.
- Takes the 5-bit opcode and the ALU overflow flag from the datapath.
- Drives every datapath control input, one state per cycle.
- Sits beside the headless machine in the processor top level; the two together form the full CPU.

---
 rtl/multicycle_control_unit_pkg.sv | 118 +++++++++++
 rtl/multicycle_control_unit_if.sv | 45 ++++
 rtl/multicycle_control_unit_decode.sv | 96 +++++++++
 rtl/multicycle_control_unit.sv | 69 ++++++
 tb/tb_multicycle_control_unit.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared types for the multicycle controller: states,
// opcodes, mux-select encodings and the control word.
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH   = 5'd0,
    S_DECODE  = 5'd1,
    S_EX_R    = 5'd2,
    S_EX_I    = 5'd3,
    S_WB_ALU  = 5'd4,
    S_MEM_RD  = 5'd5,
    S_WB_MEM  = 5'd6,
    S_MEM_WR  = 5'd7,
    S_BR_EQ   = 5'd8,
    S_BR_NE   = 5'd9,
    S_JMP     = 5'd10,
    S_PUSH_SP = 5'd11,
    S_PUSH_WR = 5'd12,
    S_POP_RD  = 5'd13,
    S_POP_WB  = 5'd14,
    S_IO_IN   = 5'd15,
    S_IO_OUT  = 5'd16,
    S_HALT    = 5'd17,
    S_ERR     = 5'd18
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_AND  = 5'h02;
  localparam logic [4:0] OP_OR   = 5'h03;
  localparam logic [4:0] OP_ADDI = 5'h04;
  localparam logic [4:0] OP_LW   = 5'h05;
  localparam logic [4:0] OP_SW   = 5'h06;
  localparam logic [4:0] OP_BEQ  = 5'h07;
  localparam logic [4:0] OP_BNE  = 5'h08;
  localparam logic [4:0] OP_J    = 5'h09;
  localparam logic [4:0] OP_PUSH = 5'h0A;
  localparam logic [4:0] OP_POP  = 5'h0B;
  localparam logic [4:0] OP_IN   = 5'h0C;
  localparam logic [4:0] OP_OUT  = 5'h0D;
  localparam logic [4:0] OP_HALT = 5'h1F;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_PASSB = 2'd3;

  localparam logic [1:0] SRCA_PC   = 2'd0;
  localparam logic [1:0] SRCA_REGA = 2'd1;
  localparam logic [1:0] SRCA_SP   = 2'd2;
  localparam logic [1:0] SRCA_MDR  = 2'd3;

  localparam logic [1:0] SRCB_REGB = 2'd0;
  localparam logic [1:0] SRCB_ONE  = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_ZERO = 2'd3;

  localparam logic [1:0] IORD_PC  = 2'd0;
  localparam logic [1:0] IORD_ALU = 2'd1;
  localparam logic [1:0] IORD_IMM = 2'd2;
  localparam logic [1:0] IORD_SP  = 2'd3;

  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_MDR = 2'd1;
  localparam logic [1:0] MTR_IN  = 2'd2;

  localparam logic [1:0] DSRC_REGA = 2'd0;
  localparam logic [1:0] OPS_REGA  = 2'd1;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_EQ   = 2'd1;
  localparam logic [1:0] BR_NE   = 2'd2;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_file_src;
    logic [1:0] data_src;
    logic [1:0] operand_src;
    logic [1:0] iord;
    logic [2:0] return_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       jump;
    logic       sp_write;
    logic [1:0] branch;
    logic       halted;
  } ctrl_word_t;

  function automatic state_t decode_next(
    input logic [4:0] op
  );
    state_t s;
    s = S_ERR;
    unique case (1'b1)
      (op <= OP_OR):    s = S_EX_R;
      (op == OP_ADDI):  s = S_EX_I;
      (op == OP_LW):    s = S_MEM_RD;
      (op == OP_SW):    s = S_MEM_WR;
      (op == OP_BEQ):   s = S_BR_EQ;
      (op == OP_BNE):   s = S_BR_NE;
      (op == OP_J):     s = S_JMP;
      (op == OP_PUSH):  s = S_PUSH_SP;
      (op == OP_POP):   s = S_POP_RD;
      (op == OP_IN):    s = S_IO_IN;
      (op == OP_OUT):   s = S_IO_OUT;
      (op == OP_HALT):  s = S_HALT;
      default:          s = S_ERR;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Controller <-> accumulator datapath bundle: status in,
// control word out.
interface multicycle_control_unit_if;
  logic [4:0] Opcode;
  logic       Overflow;
  logic [1:0] ALUOp;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] MemtoReg;
  logic [1:0] RegFileSrc;
  logic [1:0] DataSrc;
  logic [1:0] OperandSrc;
  logic [1:0] IorD;
  logic [2:0] ReturnSrc;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic       Jump;
  logic       SPWrite;
  logic [1:0] Branch;
  logic       Halted;
  logic [4:0] StateOut;

  modport master (
    input  Opcode, Overflow,
    output ALUOp, ALUSrcA, ALUSrcB,
    output MemtoReg, RegFileSrc, DataSrc,
    output OperandSrc, IorD, ReturnSrc,
    output RegWrite, MemRead, MemWrite,
    output IRWrite, PCWrite, Jump, SPWrite,
    output Branch, Halted, StateOut
  );

  modport slave (
    output Opcode, Overflow,
    input  ALUOp, ALUSrcA, ALUSrcB,
    input  MemtoReg, RegFileSrc, DataSrc,
    input  OperandSrc, IorD, ReturnSrc,
    input  RegWrite, MemRead, MemWrite,
    input  IRWrite, PCWrite, Jump, SPWrite,
    input  Branch, Halted, StateOut
  );
endinterface

// File: rtl/multicycle_control_unit_decode.sv
// Moore output map: current state -> datapath control word.
module ctrl_output_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t cw
);

  always_comb begin
    cw = '0;
    unique case (state)
      S_FETCH: begin
        cw.mem_read = 1'b1;
        cw.iord     = IORD_PC;
        cw.ir_write = 1'b1;
        cw.src_a    = SRCA_PC;
        cw.src_b    = SRCB_ONE;
        cw.alu_op   = ALU_ADD;
        cw.pc_write = 1'b1;
      end
      S_DECODE: begin
        cw.src_a  = SRCA_PC;
        cw.src_b  = SRCB_IMM;
        cw.alu_op = ALU_ADD;
      end
      S_EX_R: begin
        cw.src_a  = SRCA_REGA;
        cw.src_b  = SRCB_REGB;
        cw.alu_op = ALU_FUNCT;
      end
      S_EX_I: begin
        cw.src_a  = SRCA_REGA;
        cw.src_b  = SRCB_IMM;
        cw.alu_op = ALU_ADD;
      end
      S_WB_ALU: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = MTR_ALU;
      end
      S_MEM_RD: begin
        cw.mem_read = 1'b1;
        cw.iord     = IORD_IMM;
      end
      S_WB_MEM: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = MTR_MDR;
      end
      S_MEM_WR: begin
        cw.mem_write = 1'b1;
        cw.iord      = IORD_IMM;
        cw.data_src  = DSRC_REGA;
      end
      S_BR_EQ, S_BR_NE: begin
        cw.src_a  = SRCA_REGA;
        cw.src_b  = SRCB_REGB;
        cw.alu_op = ALU_SUB;
        cw.branch = (state == S_BR_EQ) ? BR_EQ : BR_NE;
      end
      S_JMP: begin
        cw.jump     = 1'b1;
        cw.pc_write = 1'b1;
      end
      S_PUSH_SP: begin
        cw.src_a    = SRCA_SP;
        cw.src_b    = SRCB_ONE;
        cw.alu_op   = ALU_SUB;
        cw.sp_write = 1'b1;
      end
      S_PUSH_WR: begin
        cw.mem_write = 1'b1;
        cw.iord      = IORD_SP;
        cw.data_src  = DSRC_REGA;
      end
      S_POP_RD: begin
        cw.mem_read = 1'b1;
        cw.iord     = IORD_SP;
      end
      S_POP_WB: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = MTR_MDR;
        cw.src_a      = SRCA_SP;
        cw.src_b      = SRCB_ONE;
        cw.alu_op     = ALU_ADD;
        cw.sp_write   = 1'b1;
      end
      S_IO_IN: begin
        cw.reg_write  = 1'b1;
        cw.mem_to_reg = MTR_IN;
      end
      S_IO_OUT: cw.operand_src = OPS_REGA;
      S_HALT, S_ERR: cw.halted = 1'b1;
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle sequencer for the accumulator datapath: state
// register plus next-state logic; outputs via the decoder.
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter bit HALT_ON_OVF = 1'b1
) (
  input  logic CLK,
  input  logic Reset,
  multicycle_control_unit_if.master bus
);

  state_t     state;
  state_t     state_nx;
  ctrl_word_t cw;
  logic       ovf_abort;

  ctrl_output_decode u_dec (
    .state (state),
    .cw    (cw)
  );

  assign ovf_abort = HALT_ON_OVF && bus.Overflow &&
                     (state == S_WB_ALU);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = S_FETCH;
    unique case (state)
      S_FETCH:   state_nx = S_DECODE;
      S_DECODE:  state_nx = decode_next(bus.Opcode);
      S_EX_R:    state_nx = S_WB_ALU;
      S_EX_I:    state_nx = S_WB_ALU;
      S_WB_ALU:  state_nx = ovf_abort ? S_ERR : S_FETCH;
      S_MEM_RD:  state_nx = S_WB_MEM;
      S_PUSH_SP: state_nx = S_PUSH_WR;
      S_POP_RD:  state_nx = S_POP_WB;
      S_HALT:    state_nx = S_HALT;
      S_ERR:     state_nx = S_ERR;
      default:   state_nx = S_FETCH;
    endcase
  end

  // The overflow abort suppresses the writeback of a bad result.
  assign bus.RegWrite   = cw.reg_write & ~ovf_abort;
  assign bus.ALUOp      = cw.alu_op;
  assign bus.ALUSrcA    = cw.src_a;
  assign bus.ALUSrcB    = cw.src_b;
  assign bus.MemtoReg   = cw.mem_to_reg;
  assign bus.RegFileSrc = cw.reg_file_src;
  assign bus.DataSrc    = cw.data_src;
  assign bus.OperandSrc = cw.operand_src;
  assign bus.IorD       = cw.iord;
  assign bus.ReturnSrc  = cw.return_src;
  assign bus.MemRead    = cw.mem_read;
  assign bus.MemWrite   = cw.mem_write;
  assign bus.IRWrite    = cw.ir_write;
  assign bus.PCWrite    = cw.pc_write;
  assign bus.Jump       = cw.jump;
  assign bus.SPWrite    = cw.sp_write;
  assign bus.Branch     = cw.branch;
  assign bus.Halted     = cw.halted;
  assign bus.StateOut   = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: instruction-step
// model checked every cycle plus literal spot checks.
module tb_multicycle_control_unit;
  import cpu_ctrl_pkg::*;

  localparam bit HOV = 1'b1;

  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3;
  localparam int C_BEQ = 4, C_BNE = 5, C_J = 6;
  localparam int C_PUSH = 7, C_POP = 8, C_IN = 9;
  localparam int C_OUT = 10, C_HALT = 11, C_ERR = 12;

  typedef struct packed {
    logic [1:0] aluop;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] mtr;
    logic [1:0] rfs;
    logic [1:0] dsrc;
    logic [1:0] osrc;
    logic [1:0] iord;
    logic [2:0] rsrc;
    logic       rw;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       pcw;
    logic       jmp;
    logic       spw;
    logic [1:0] br;
    logic       halted;
    logic [4:0] st;
  } obs_t;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  int n_cmp = 0;
  int n_mis = 0;

  // k: step within instruction (0 = FETCH); stop: 1 halt, 2 err
  int k = 0;
  int stop = 0;

  multicycle_control_unit_if bus();

  multicycle_control_unit #(.HALT_ON_OVF(HOV)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  function automatic int cls(input logic [4:0] op);
    if (op <= 5'd3) return C_R;
    case (op)
      5'h04: return C_I;
      5'h05: return C_LW;
      5'h06: return C_SW;
      5'h07: return C_BEQ;
      5'h08: return C_BNE;
      5'h09: return C_J;
      5'h0A: return C_PUSH;
      5'h0B: return C_POP;
      5'h0C: return C_IN;
      5'h0D: return C_OUT;
      5'h1F: return C_HALT;
      default: return C_ERR;
    endcase
  endfunction

  function automatic int steps(input int c);
    if (c == C_R || c == C_I || c == C_LW ||
        c == C_PUSH || c == C_POP) return 4;
    return 3;
  endfunction

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      k = 0;
      stop = 0;
    end else if (stop == 0) begin
      if (k == 1 && cls(bus.Opcode) == C_HALT)
        stop = 1;
      else if (k == 1 && cls(bus.Opcode) == C_ERR)
        stop = 2;
      else if (k == 3 && steps(cls(bus.Opcode)) == 4 &&
               cls(bus.Opcode) <= C_I && HOV &&
               bus.Overflow)
        stop = 2;
      else if (k + 1 >= steps(cls(bus.Opcode)) && k >= 2)
        k = 0;
      else
        k = k + 1;
    end
  end

  function automatic obs_t expect_now();
    obs_t e;
    int c;
    e = '0;
    c = cls(bus.Opcode);
    if (stop != 0) begin
      e.halted = 1'b1;
      e.st = (stop == 1) ? S_HALT : S_ERR;
    end else if (k == 0) begin
      e.mr = 1; e.irw = 1; e.srcb = 1; e.pcw = 1;
      e.st = S_FETCH;
    end else if (k == 1) begin
      e.srcb = 2;
      e.st = S_DECODE;
    end else if (k == 2) begin
      case (c)
        C_R: begin
          e.srca = 1; e.aluop = 2; e.st = S_EX_R;
        end
        C_I: begin
          e.srca = 1; e.srcb = 2; e.st = S_EX_I;
        end
        C_LW: begin
          e.mr = 1; e.iord = 2; e.st = S_MEM_RD;
        end
        C_SW: begin
          e.mw = 1; e.iord = 2; e.st = S_MEM_WR;
        end
        C_BEQ, C_BNE: begin
          e.srca = 1; e.aluop = 1;
          e.br = (c == C_BEQ) ? 2'd1 : 2'd2;
          e.st = (c == C_BEQ) ? S_BR_EQ : S_BR_NE;
        end
        C_J: begin
          e.jmp = 1; e.pcw = 1; e.st = S_JMP;
        end
        C_PUSH: begin
          e.srca = 2; e.srcb = 1; e.aluop = 1; e.spw = 1;
          e.st = S_PUSH_SP;
        end
        C_POP: begin
          e.mr = 1; e.iord = 3; e.st = S_POP_RD;
        end
        C_IN: begin
          e.rw = 1; e.mtr = 2; e.st = S_IO_IN;
        end
        default: begin
          e.osrc = 1; e.st = S_IO_OUT;
        end
      endcase
    end else begin
      case (c)
        C_R, C_I: begin
          e.rw = !(HOV && bus.Overflow); e.st = S_WB_ALU;
        end
        C_LW: begin
          e.rw = 1; e.mtr = 1; e.st = S_WB_MEM;
        end
        C_PUSH: begin
          e.mw = 1; e.iord = 3; e.st = S_PUSH_WR;
        end
        default: begin
          e.rw = 1; e.mtr = 1; e.srca = 2; e.srcb = 1;
          e.spw = 1; e.st = S_POP_WB;
        end
      endcase
    end
    return e;
  endfunction

  function automatic obs_t observed();
    obs_t o;
    o.aluop  = bus.ALUOp;
    o.srca   = bus.ALUSrcA;
    o.srcb   = bus.ALUSrcB;
    o.mtr    = bus.MemtoReg;
    o.rfs    = bus.RegFileSrc;
    o.dsrc   = bus.DataSrc;
    o.osrc   = bus.OperandSrc;
    o.iord   = bus.IorD;
    o.rsrc   = bus.ReturnSrc;
    o.rw     = bus.RegWrite;
    o.mr     = bus.MemRead;
    o.mw     = bus.MemWrite;
    o.irw    = bus.IRWrite;
    o.pcw    = bus.PCWrite;
    o.jmp    = bus.Jump;
    o.spw    = bus.SPWrite;
    o.br     = bus.Branch;
    o.halted = bus.Halted;
    o.st     = bus.StateOut;
    return o;
  endfunction

  always @(negedge CLK) begin
    obs_t e;
    obs_t a;
    e = expect_now();
    a = observed();
    n_cmp++;
    if (a !== e) begin
      n_mis++;
      $display("FAIL cycle_word t=%0t got=%h want=%h",
               $time, a, e);
    end
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  task automatic run_instr(input string nm,
                           input logic [4:0] op,
                           input logic ovf, input int lat);
    int n;
    n = 0;
    bus.Opcode = op;
    bus.Overflow = ovf;
    do begin
      step();
      n++;
    end while (bus.StateOut != 5'd0 && n < 12);
    chk({nm, "_latency"}, n, lat);
  endtask

  initial begin
    bus.Opcode = 5'h00;
    bus.Overflow = 1'b0;
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    chk("reset_state", int'(bus.StateOut), 0);
    chk("reset_memread", int'(bus.MemRead), 1);

    // reset mid-DECODE
    bus.Opcode = 5'h00;
    step();
    chk("in_decode", int'(bus.StateOut), 1);
    Reset = 1'b1;
    #1;
    chk("async_fetch", int'(bus.StateOut), 0);
    step();
    Reset = 1'b0;
    @(negedge CLK);
    #1;
    chk("post_rst_mr", int'(bus.MemRead), 1);
    chk("post_rst_irw", int'(bus.IRWrite), 1);
    chk("post_rst_pcw", int'(bus.PCWrite), 1);
    step();
    step();
    step();
    step();
    chk("add_after_rst_fetch", int'(bus.StateOut), 0);

    // ADD walk-through
    bus.Opcode = 5'h00;
    step();
    chk("add_rw_decode", int'(bus.RegWrite), 0);
    step();
    chk("add_exr_aluop", int'(bus.ALUOp), 2);
    chk("add_exr_rw", int'(bus.RegWrite), 0);
    step();
    chk("add_wb_rw", int'(bus.RegWrite), 1);
    step();
    chk("add_back_fetch", int'(bus.StateOut), 0);

    // PUSH walk-through
    bus.Opcode = 5'h0A;
    step();
    step();
    chk("push_sp_spw", int'(bus.SPWrite), 1);
    chk("push_sp_aluop", int'(bus.ALUOp), 1);
    step();
    chk("push_wr_mw", int'(bus.MemWrite), 1);
    chk("push_wr_iord", int'(bus.IorD), 3);
    step();
    chk("push_back_fetch", int'(bus.StateOut), 0);

    // BNE
    bus.Opcode = 5'h08;
    step();
    step();
    chk("bne_branch", int'(bus.Branch), 2);
    chk("bne_aluop", int'(bus.ALUOp), 1);
    chk("bne_jump", int'(bus.Jump), 0);
    step();
    chk("bne_back_fetch", int'(bus.StateOut), 0);

    run_instr("sub", 5'h01, 1'b0, 4);
    run_instr("and", 5'h02, 1'b0, 4);
    run_instr("or", 5'h03, 1'b0, 4);
    run_instr("addi", 5'h04, 1'b0, 4);
    run_instr("lw", 5'h05, 1'b0, 4);
    run_instr("sw", 5'h06, 1'b0, 3);
    run_instr("sw_ovf", 5'h06, 1'b1, 3);
    run_instr("beq", 5'h07, 1'b0, 3);
    run_instr("j", 5'h09, 1'b0, 3);
    run_instr("pop", 5'h0B, 1'b0, 4);
    run_instr("in", 5'h0C, 1'b0, 3);
    run_instr("out", 5'h0D, 1'b0, 3);
    run_instr("push", 5'h0A, 1'b0, 4);

    // reset during a memory write drops the strobe at once
    bus.Opcode = 5'h0A;
    step();
    step();
    step();
    chk("mw_before_rst", int'(bus.MemWrite), 1);
    Reset = 1'b1;
    #1;
    chk("mw_dropped", int'(bus.MemWrite), 0);
    step();
    Reset = 1'b0;

    // ADDI with overflow aborts
    bus.Opcode = 5'h04;
    bus.Overflow = 1'b1;
    step();
    step();
    step();
    chk("ovf_wb_rw", int'(bus.RegWrite), 0);
    step();
    chk("ovf_err_state", int'(bus.StateOut), 18);
    chk("ovf_halted", int'(bus.Halted), 1);
    repeat (5) step();
    chk("ovf_err_hold", int'(bus.StateOut), 18);
    bus.Overflow = 1'b0;
    pulse_reset();
    chk("ovf_reset_exit", int'(bus.StateOut), 0);

    // undefined opcode
    bus.Opcode = 5'h15;
    step();
    step();
    chk("undef_err", int'(bus.StateOut), 18);
    repeat (20) step();
    chk("undef_halted", int'(bus.Halted), 1);
    chk("undef_mw", int'(bus.MemWrite), 0);
    pulse_reset();

    // HALT
    bus.Opcode = 5'h1F;
    step();
    step();
    chk("halt_state", int'(bus.StateOut), 17);
    repeat (4) step();
    chk("halt_halted", int'(bus.Halted), 1);
    pulse_reset();
    run_instr("after_halt_add", 5'h00, 1'b0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
